// File: rtl/flexbus_regbank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : flexbus_regbank
// Description : FlexBus slave register bank. NREG read/write control words
//               and NSTAT read-only status words behind a base/mask address
//               decode, with programmable wait states before FB_TA_n and a
//               one-cycle write strobe per register.
//               Optional byte-lane writes: define FLEXBUS_REGBANK_BE_EN to add
//               the FB_BE_n input (active-low lane enables).
// Revision    : 1.0 - initial release
// ============================================================================
module flexbus_regbank #(
    parameter logic [31:0] FB_BASE   = 32'h6000_0000,
    parameter logic [31:0] BASE_MASK = 32'hF000_0000,
    parameter int          NREG      = 8,
    parameter int          NSTAT     = 2,
    parameter int          WAIT_CYC  = 1,
    parameter logic [31:0] REG_RST   = 32'h0000_0000
) (
    input  logic                                   FB_CLK,
    input  logic                                   RST,
    input  logic                                   FB_ALE,
    input  logic                                   FB_CS,
    input  logic                                   FB_RW,
    input  logic [31:0]                            FB_AD_I,
`ifdef FLEXBUS_REGBANK_BE_EN
    input  logic [3:0]                             FB_BE_n,
`endif
    input  logic [((NSTAT > 0) ? NSTAT : 1)*32-1:0] STAT_Din,
    output logic [31:0]                            FB_AD_O,
    output logic                                   FB_AD_OE,
    output logic                                   FB_TA_n,
    output logic [NREG*32-1:0]                     REG_Qout,
    output logic [NREG-1:0]                        REG_WSTB
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam logic [3:0] c_wait = 4'(WAIT_CYC);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [29:0] r_idx;
    logic        r_rw;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;

    logic        w_hit;
    logic [29:0] w_idx;
    logic        w_rw_eff;
    logic        w_load_rd;
    logic        w_commit;
    logic [31:0] w_bmask;
    logic [31:0] w_rdata;

    // Address decode of whatever is currently on the pad
    assign w_hit = (((FB_AD_I ^ FB_BASE) & BASE_MASK) == 32'h0);
    assign w_idx = 30'((FB_AD_I & ~BASE_MASK) >> 2);

    // Direction is only latched on leaving ADDR, so use the live pin then
`ifdef FLEXBUS_REGBANK_BE_EN
    assign w_bmask = {{8{~FB_BE_n[3]}}, {8{~FB_BE_n[2]}},
                      {8{~FB_BE_n[1]}}, {8{~FB_BE_n[0]}}};
`else
    assign w_bmask = 32'hFFFF_FFFF;
`endif
    assign w_rw_eff  = (r_state == S_ADDR) ? FB_RW : r_rw;
    assign w_load_rd = (r_state != S_ACK) && (w_state_nxt == S_ACK) && w_rw_eff;
    // A write lands only when the ACK cycle completes without abort/restart
    assign w_commit  = (r_state == S_ACK) && !r_rw && !FB_ALE && !FB_CS &&
                       (w_bmask != 32'h0);

    // State register
    always_ff @(posedge FB_CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a new address phase always wins over the current one
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (FB_ALE && w_hit) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (FB_ALE) begin
                    w_state_nxt = w_hit ? S_ADDR : S_IDLE;
                end else if (!FB_CS) begin
                    w_state_nxt = (c_wait == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (FB_ALE) begin
                    w_state_nxt = w_hit ? S_ADDR : S_IDLE;
                end else if (FB_CS) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (FB_ALE && w_hit) begin
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs derived from the current state
    always_comb begin
        FB_TA_n  = 1'b1;
        FB_AD_OE = 1'b0;
        if (r_state == S_ACK) begin
            FB_TA_n  = 1'b0;
            FB_AD_OE = r_rw;
        end
    end

    // Read source select: RW register, status word, or zero when unmapped
    always_comb begin
        w_rdata = 32'h0;
        for (int i = 0; i < NREG; i++) begin
            if (r_idx == 30'(i)) begin
                w_rdata = REG_Qout[32*i +: 32];
            end
        end
        for (int s = 0; s < NSTAT; s++) begin
            if (r_idx == 30'(NREG + s)) begin
                w_rdata = STAT_Din[32*s +: 32];
            end
        end
    end

    // Address/direction latch, wait counter and read data register
    always_ff @(posedge FB_CLK) begin
        if (RST) begin
            r_idx   <= '0;
            r_rw    <= 1'b0;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
        end else begin
            if (FB_ALE && w_hit) begin
                r_idx <= w_idx;
            end
            if ((r_state == S_ADDR) && !FB_ALE && !FB_CS) begin
                r_rw  <= FB_RW;
                r_cnt <= c_wait;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_load_rd) begin
                r_rdata <= w_rdata;
            end
        end
    end

    assign FB_AD_O = r_rdata;

    // One storage word and strobe per RW register
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [31:0] r_q;
        logic        r_stb;
        logic        w_sel;

        assign w_sel = w_commit && (r_idx == 30'(gi));

        // Merge enabled lanes of the bus data into the register on commit
        always_ff @(posedge FB_CLK) begin
            if (RST) begin
                r_q   <= REG_RST;
                r_stb <= 1'b0;
            end else begin
                r_stb <= w_sel;
                if (w_sel) begin
                    r_q <= (r_q & ~w_bmask) | (FB_AD_I & w_bmask);
                end
            end
        end

        assign REG_Qout[32*gi +: 32] = r_q;
        assign REG_WSTB[gi]          = r_stb;
    end

endmodule
`default_nettype wire
